// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: data width, bit-period width,
// the receive state encoding and the parity helper.
// Build option: UART_RX_PARITY_EN adds the PARITY state and parity checking.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BP_W      = 19;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // 1 when the received parity bit disagrees with the selected sense.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit,
                                           input logic                 odd);
    logic x;
    x = (^data) ^ par_bit;
    return odd ? ~x : x;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;
`endif

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer for the UART receiver: counts clock cycles within the current
// bit and pulses tick at mid-start (half period) or after a full period.
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            active_i,
  input  logic            half_i,
  input  logic [BP_W-1:0] bit_period_i,
  output logic            tick_o
);

  logic [BP_W-1:0] cnt_q;
  logic [BP_W-1:0] cnt_d;
  logic [BP_W-1:0] target;

  // Half a period to reach mid start bit, full periods afterwards.
  always_comb begin
    target = half_i ? (bit_period_i >> 1) : bit_period_i;
  end

  assign tick_o = active_i && (cnt_q == target);

  // Counter restarts from zero when idle or at every tick.
  always_comb begin
    cnt_d = cnt_q + BP_W'(1);
    if (!active_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Reports framing, parity and overrun errors alongside each received byte.
// Build option: UART_RX_PARITY_EN enables the parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [BP_W-1:0]      bit_period,
  input  logic [1:0]           parity_sel,
  input  logic                 rd_strobe,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  rx_state_e              state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   ready_q;
  logic                   framing_q;
  logic                   overrun_q;
  logic                   wait_high_q;
  logic                   bit_tick;

`ifdef UART_RX_PARITY_EN
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_bad_q;
  logic                   parity_q;
`else
  logic                   unused_parity_sel;
  assign unused_parity_sel = ^parity_sel;
`endif

  // Metastability chain on the raw line; idles high out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  rx_bit_timer u_timer (
    .clk_i        (clock),
    .rst_i        (reset),
    .active_i     (state_q != IDLE),
    .half_i       (state_q == START),
    .bit_period_i (bit_period),
    .tick_o       (bit_tick)
  );

  // Frame sequencing, byte assembly and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      framing_q   <= 1'b0;
      overrun_q   <= 1'b0;
      wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      par_bad_q   <= 1'b0;
      parity_q    <= 1'b0;
`endif
    end else begin
      // A line that ended a frame low must return high before a new start.
      if (rxs) begin
        wait_high_q <= 1'b0;
      end

      // Consumer read; a STOP tick in the same cycle overrides below.
      if (rd_strobe) begin
        ready_q   <= 1'b0;
        framing_q <= 1'b0;
        overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_q  <= 1'b0;
`endif
      end

      case (state_q)
        IDLE: begin
          if (!rxs && !wait_high_q) begin
            state_q <= START;
          end
        end

        START: begin
          if (bit_tick) begin
            if (!rxs) begin
              state_q   <= DATA;
              idx_q     <= '0;
`ifdef UART_RX_PARITY_EN
              par_en_q  <= parity_sel[0];
              par_odd_q <= parity_sel[1];
              par_bad_q <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end

        DATA: begin
          if (bit_tick) begin
            shift_q[idx_q] <= rxs;
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= par_en_q ? PARITY : STOP;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            par_bad_q <= parity_mismatch(shift_q, rxs, par_odd_q);
            state_q   <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_tick) begin
            data_q      <= shift_q;
            framing_q   <= ~rxs;
            ready_q     <= 1'b1;
            overrun_q   <= ready_q & ~rd_strobe;
            wait_high_q <= ~rxs;
`ifdef UART_RX_PARITY_EN
            parity_q    <= par_en_q & par_bad_q;
`endif
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = data_q;
  assign rx_ready    = ready_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
